branch_predictor_btb: RTL and testbench
=======================================

Name: branch_predictor_btb

Overview:
Parametrised branch target buffer (BTB) plus direction predictor. It serves the IF stage with a same-cycle next-PC prediction and is trained by the resolution stage, one update per cycle. It carries the num_branch / num_branch_miss statistics counters, so the datapath no longer keeps them. Mode, table depth and counter width are set at elaboration.

Parameters:
WORD_SIZE, 16, width of PC, target and statistics counters (word-addressed PC).
INDEX_BITS, 8, log2 of BTB entries; entry index = pc[INDEX_BITS-1:0]; tag = pc[WORD_SIZE-1:INDEX_BITS].
COUNTER_BITS, 2, width of the per-entry saturating direction counter (>=1).
PREDICT_MODE, 2, 0 = static not-taken, 1 = taken on BTB hit, 2 = saturating counter.

Ports:
clk  input  1  clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
pc  input  WORD_SIZE  IF-stage lookup PC.
predicted_taken  output  1  prediction for pc (combinational).
predicted_pc  output  WORD_SIZE  predicted next PC for pc (combinational).
update_valid  input  1  resolved control instruction this cycle.
update_is_jump  input  1  unconditional jump (1) vs conditional branch (0).
update_pc  input  WORD_SIZE  PC of the resolved instruction.
update_taken  input  1  actual direction (forced to 1 internally when update_is_jump).
update_target  input  WORD_SIZE  actual taken target.
update_predicted_pc  input  WORD_SIZE  next PC that was predicted for update_pc.
mispredict  output  1  combinational; update_valid && actual_next != update_predicted_pc.
correct_pc  output  WORD_SIZE  actual_next = taken ? update_target : update_pc+1.
stat_clear  input  1  synchronous clear of the statistics counters.
num_branch  output  WORD_SIZE  count of updates.
num_branch_miss  output  WORD_SIZE  count of mispredicts.

Behaviour:
- Entry contents: valid, tag, target[WORD_SIZE], ctr[COUNTER_BITS]. WNT = 2^(C-1)-1; WT = 2^(C-1); MAX = 2^C-1.
- Reset (async, reset_n=0): all valid=0, all ctr=WNT, num_branch=0, num_branch_miss=0. Reset mid-operation discards any pending update.
- Lookup (0 latency, combinational): hit = valid[idx] && tag match.
  - Mode 0: taken = 0.
  - Mode 1: taken = hit.
  - Mode 2: taken = hit && ctr MSB.
  - predicted_pc = taken ? target : pc+1, wrapping mod 2^WORD_SIZE (0xFFFF -> 0x0000).
- Update (registered on rising clk when update_valid):
  - Hit, taken: ctr = min(ctr+1, MAX); target overwritten.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate/evict the slot. Write valid=1, new tag, target. ctr = WT for a branch, MAX for a jump.
  - Miss, not taken: no change.
- Read-during-write: a lookup in the same cycle as an update to the same index sees the pre-update contents. The new contents are visible from the next cycle.
- Table training occurs in all modes; the mode only affects lookup.
- Statistics:
  - On update_valid, num_branch += 1.
  - On mispredict, num_branch_miss += 1.
  - Both wrap mod 2^WORD_SIZE.
  - stat_clear has priority over a simultaneous increment; both counters read 0 the next cycle.
- The table is not cleared by stat_clear.

Decomposition:
- PREDICT_MODE encodings (PRED_STATIC_NT, PRED_BTB_HIT, PRED_SATCTR) go into constants.v next to WORD_SIZE.
- One natural sub-module: sat_counter_update, a combinational next-value function (COUNTER_BITS, inc/dec, saturate).
- Table storage is inferred register arrays inside the top.

Test Plan:
1. Reset, then lookup pc=0x0010 -> predicted_taken=0, predicted_pc=0x0011; num_branch=0, num_branch_miss=0.
2. Mode 2, update pc=0x0020, taken, target=0x0040, predicted_pc=0x0021 -> mispredict=1, correct_pc=0x0040. Next cycle lookup 0x0020 -> taken=1, predicted_pc=0x0040; num_branch=1, num_branch_miss=1.
3. Saturation:
   - 3 more taken updates on 0x0020 -> ctr held at 3.
   - One not-taken update -> still predicts 0x0040.
   - Second not-taken update -> predicts 0x0021.
   - Same-cycle lookup during the second update still returns 0x0040.
4. Aliasing (INDEX_BITS=8): 0x0120 looks up as a miss -> 0x0121. A taken update at 0x0120 (target 0x0200) evicts it; afterwards lookup 0x0020 -> 0x0021 and lookup 0x0120 -> 0x0200.
5. Modes:
   - Mode 0 with test 2's training: predicted_taken always 0, every taken update mispredicts.
   - Mode 1: a jump at 0xFFFF, target 0x0005, predicts 0x0005 on the next lookup.
   - A not-taken lookup at 0xFFFF wraps to 0x0000.
6. stat_clear asserted in the same cycle as a mispredicting update -> both counters 0 next cycle, table entry still written. Pulse reset_n mid-run -> all lookups miss.

Source files
------------

// File: rtl/branch_predictor_btb_pkg.sv
// Shared constants and helpers for the branch target buffer / direction predictor.
// Prediction-mode encodings live next to the default word size.
package branch_predictor_btb_pkg;

    localparam int WORD_SIZE_DEFAULT = 16;

    localparam int PRED_STATIC_NT = 0;
    localparam int PRED_BTB_HIT   = 1;
    localparam int PRED_SATCTR    = 2;

    // Counter landmarks for an n-bit saturating direction counter.
    function automatic int unsigned ctr_weak_nt(input int unsigned bits);
        return (32'd1 << (bits - 1)) - 32'd1;
    endfunction

    function automatic int unsigned ctr_weak_t(input int unsigned bits);
        return 32'd1 << (bits - 1);
    endfunction

    function automatic int unsigned ctr_max(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_btb_sat_counter_update.sv
// Combinational next value of a saturating up/down counter.
// Increments clamp at all-ones, decrements clamp at zero.
module sat_counter_update
    import branch_predictor_btb_pkg::*;
#(
    parameter int COUNTER_BITS = 2
) (
    input  logic [COUNTER_BITS-1:0] ctr,
    input  logic                    inc,
    output logic [COUNTER_BITS-1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (inc) begin
            if (ctr != {COUNTER_BITS{1'b1}}) begin
                ctr_next = ctr + 1'b1;
            end
        end else begin
            if (ctr != {COUNTER_BITS{1'b0}}) begin
                ctr_next = ctr - 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with mode-selectable direction prediction,
// trained by the resolution stage, plus branch / mispredict statistics counters.
module branch_predictor_btb
    import branch_predictor_btb_pkg::*;
#(
    parameter int WORD_SIZE    = WORD_SIZE_DEFAULT,
    parameter int INDEX_BITS   = 8,
    parameter int COUNTER_BITS = 2,
    parameter int PREDICT_MODE = PRED_SATCTR
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] pc,
    output logic                 predicted_taken,
    output logic [WORD_SIZE-1:0] predicted_pc,
    input  logic                 update_valid,
    input  logic                 update_is_jump,
    input  logic [WORD_SIZE-1:0] update_pc,
    input  logic                 update_taken,
    input  logic [WORD_SIZE-1:0] update_target,
    input  logic [WORD_SIZE-1:0] update_predicted_pc,
    output logic                 mispredict,
    output logic [WORD_SIZE-1:0] correct_pc,
    input  logic                 stat_clear,
    output logic [WORD_SIZE-1:0] num_branch,
    output logic [WORD_SIZE-1:0] num_branch_miss
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = WORD_SIZE - INDEX_BITS;

    localparam logic [COUNTER_BITS-1:0] CTR_WNT = COUNTER_BITS'(ctr_weak_nt(COUNTER_BITS));
    localparam logic [COUNTER_BITS-1:0] CTR_WT  = COUNTER_BITS'(ctr_weak_t(COUNTER_BITS));
    localparam logic [COUNTER_BITS-1:0] CTR_MAX = COUNTER_BITS'(ctr_max(COUNTER_BITS));

    logic [ENTRIES-1:0]      valid_q, valid_d;
    logic [TAG_W-1:0]        tag_q    [ENTRIES];
    logic [TAG_W-1:0]        tag_d    [ENTRIES];
    logic [WORD_SIZE-1:0]    target_q [ENTRIES];
    logic [WORD_SIZE-1:0]    target_d [ENTRIES];
    logic [COUNTER_BITS-1:0] ctr_q    [ENTRIES];
    logic [COUNTER_BITS-1:0] ctr_d    [ENTRIES];

    logic [WORD_SIZE-1:0] num_branch_q, num_branch_d;
    logic [WORD_SIZE-1:0] num_branch_miss_q, num_branch_miss_d;

    // Lookup path: reads only registered state, so a same-cycle update is not seen.
    logic [INDEX_BITS-1:0]   lk_idx;
    logic [TAG_W-1:0]        lk_tag;
    logic                    lk_hit;
    logic [COUNTER_BITS-1:0] lk_ctr;

    always_comb begin
        lk_idx = pc[INDEX_BITS-1:0];
        lk_tag = pc[WORD_SIZE-1:INDEX_BITS];
        lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_ctr = ctr_q[lk_idx];

        predicted_taken = 1'b0;
        if (PREDICT_MODE == PRED_BTB_HIT) begin
            predicted_taken = lk_hit;
        end else if (PREDICT_MODE == PRED_SATCTR) begin
            predicted_taken = lk_hit && lk_ctr[COUNTER_BITS-1];
        end

        predicted_pc = predicted_taken ? target_q[lk_idx] : pc + 1'b1;
    end

    // Resolution path.
    logic [INDEX_BITS-1:0]   up_idx;
    logic [TAG_W-1:0]        up_tag;
    logic                    up_hit;
    logic                    up_taken;
    logic [COUNTER_BITS-1:0] up_ctr_next;

    always_comb begin
        up_idx     = update_pc[INDEX_BITS-1:0];
        up_tag     = update_pc[WORD_SIZE-1:INDEX_BITS];
        up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        up_taken   = update_taken || update_is_jump;
        correct_pc = up_taken ? update_target : update_pc + 1'b1;
        mispredict = update_valid && (correct_pc != update_predicted_pc);
    end

    sat_counter_update #(
        .COUNTER_BITS (COUNTER_BITS)
    ) u_sat_counter_update (
        .ctr      (ctr_q[up_idx]),
        .inc      (up_taken),
        .ctr_next (up_ctr_next)
    );

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (update_valid) begin
            if (up_hit) begin
                ctr_d[up_idx] = up_ctr_next;
                if (up_taken) begin
                    target_d[up_idx] = update_target;
                end
            end else if (up_taken) begin
                // Allocation evicts whatever aliased entry held this slot.
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = update_target;
                ctr_d[up_idx]    = update_is_jump ? CTR_MAX : CTR_WT;
            end
        end
    end

    always_comb begin
        num_branch_d      = num_branch_q;
        num_branch_miss_d = num_branch_miss_q;
        if (stat_clear) begin
            num_branch_d      = '0;
            num_branch_miss_d = '0;
        end else begin
            if (update_valid) begin
                num_branch_d = num_branch_q + 1'b1;
            end
            if (mispredict) begin
                num_branch_miss_d = num_branch_miss_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q           <= '0;
            num_branch_q      <= '0;
            num_branch_miss_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WNT;
            end
        end else begin
            valid_q           <= valid_d;
            num_branch_q      <= num_branch_d;
            num_branch_miss_q <= num_branch_miss_d;
            ctr_q             <= ctr_d;
        end
    end

    // Tag and target are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

    assign num_branch      = num_branch_q;
    assign num_branch_miss = num_branch_miss_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench: three predictor instances (one per mode) share stimulus;
// expectations are queued as stimulus is driven and drained once outputs settle.
module tb_branch_predictor_btb;

    logic        clk;
    logic        reset_n;
    logic [15:0] pc;
    logic        update_valid, update_is_jump, update_taken, stat_clear;
    logic [15:0] update_pc, update_target, update_predicted_pc;

    logic        tk0, tk1, tk2;
    logic [15:0] ppc0, ppc1, ppc2;
    logic        mis0, mis1, mis2;
    logic [15:0] cpc0, cpc1, cpc2;
    logic [15:0] nb0, nb1, nb2, nbm0, nbm1, nbm2;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int S_TK0 = 0, S_TK1 = 1, S_TK2 = 2, S_PC0 = 3, S_PC1 = 4, S_PC2 = 5;
    localparam int S_MIS = 6, S_CPC = 7, S_NB = 8, S_NBM = 9;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] exp;
    } exp_t;

    exp_t sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_btb #(.WORD_SIZE(16), .INDEX_BITS(8), .COUNTER_BITS(2), .PREDICT_MODE(0)) u_m0 (
        .clk(clk), .reset_n(reset_n), .pc(pc), .predicted_taken(tk0), .predicted_pc(ppc0),
        .update_valid(update_valid), .update_is_jump(update_is_jump), .update_pc(update_pc),
        .update_taken(update_taken), .update_target(update_target),
        .update_predicted_pc(update_predicted_pc), .mispredict(mis0), .correct_pc(cpc0),
        .stat_clear(stat_clear), .num_branch(nb0), .num_branch_miss(nbm0));

    branch_predictor_btb #(.WORD_SIZE(16), .INDEX_BITS(8), .COUNTER_BITS(2), .PREDICT_MODE(1)) u_m1 (
        .clk(clk), .reset_n(reset_n), .pc(pc), .predicted_taken(tk1), .predicted_pc(ppc1),
        .update_valid(update_valid), .update_is_jump(update_is_jump), .update_pc(update_pc),
        .update_taken(update_taken), .update_target(update_target),
        .update_predicted_pc(update_predicted_pc), .mispredict(mis1), .correct_pc(cpc1),
        .stat_clear(stat_clear), .num_branch(nb1), .num_branch_miss(nbm1));

    branch_predictor_btb #(.WORD_SIZE(16), .INDEX_BITS(8), .COUNTER_BITS(2), .PREDICT_MODE(2)) u_m2 (
        .clk(clk), .reset_n(reset_n), .pc(pc), .predicted_taken(tk2), .predicted_pc(ppc2),
        .update_valid(update_valid), .update_is_jump(update_is_jump), .update_pc(update_pc),
        .update_taken(update_taken), .update_target(update_target),
        .update_predicted_pc(update_predicted_pc), .mispredict(mis2), .correct_pc(cpc2),
        .stat_clear(stat_clear), .num_branch(nb2), .num_branch_miss(nbm2));

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h, want 0x%04h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            S_TK0:   return {15'd0, tk0};
            S_TK1:   return {15'd0, tk1};
            S_TK2:   return {15'd0, tk2};
            S_PC0:   return ppc0;
            S_PC1:   return ppc1;
            S_PC2:   return ppc2;
            S_MIS:   return {15'd0, mis2};
            S_CPC:   return cpc2;
            S_NB:    return nb2;
            S_NBM:   return nbm2;
            default: return 16'hxxxx;
        endcase
    endfunction

    task automatic sb_push(input string tag, input int sel, input logic [15:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic settle();
        exp_t e;
        #2;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_upd(input logic j, input logic [15:0] p, input logic t,
                             input logic [15:0] tgt, input logic [15:0] pp);
        update_valid        = 1'b1;
        update_is_jump      = j;
        update_pc           = p;
        update_taken        = t;
        update_target       = tgt;
        update_predicted_pc = pp;
    endtask

    task automatic idle_upd();
        update_valid   = 1'b0;
        update_is_jump = 1'b0;
        update_taken   = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        pc = 16'h0010;
        stat_clear = 1'b0;
        update_pc = '0;
        update_target = '0;
        update_predicted_pc = '0;
        idle_upd();

        // Reset state and cold lookup
        repeat (2) @(posedge clk);
        #1;
        sb_push("rst_nb_held", S_NB, 16'h0000);
        settle();
        reset_n = 1'b1;
        sb_push("cold_tk0", S_TK0, 16'h0000);
        sb_push("cold_tk1", S_TK1, 16'h0000);
        sb_push("cold_tk2", S_TK2, 16'h0000);
        sb_push("cold_ppc", S_PC2, 16'h0011);
        sb_push("cold_nb",  S_NB,  16'h0000);
        sb_push("cold_nbm", S_NBM, 16'h0000);
        sb_push("cold_mis", S_MIS, 16'h0000);
        settle();

        // First taken branch allocates
        tick();
        pc = 16'h0020;
        drive_upd(1'b0, 16'h0020, 1'b1, 16'h0040, 16'h0021);
        sb_push("alloc_mis", S_MIS, 16'h0001);
        sb_push("alloc_cpc", S_CPC, 16'h0040);
        sb_push("alloc_same_cyc", S_PC2, 16'h0021);
        settle();
        tick();
        idle_upd();
        sb_push("alloc_m0_ppc", S_PC0, 16'h0021);
        sb_push("alloc_m1_ppc", S_PC1, 16'h0040);
        sb_push("alloc_m2_ppc", S_PC2, 16'h0040);
        sb_push("alloc_m2_tk",  S_TK2, 16'h0001);
        sb_push("alloc_nb",  S_NB,  16'h0001);
        sb_push("alloc_nbm", S_NBM, 16'h0001);
        settle();

        // Saturation then decay
        for (int i = 0; i < 3; i++) begin
            tick();
            drive_upd(1'b0, 16'h0020, 1'b1, 16'h0040, 16'h0040);
            sb_push("sat_mis", S_MIS, 16'h0000);
            settle();
        end
        tick();
        idle_upd();
        sb_push("sat_ppc", S_PC2, 16'h0040);
        sb_push("sat_nb",  S_NB,  16'h0004);
        sb_push("sat_nbm", S_NBM, 16'h0001);
        settle();
        tick();
        drive_upd(1'b0, 16'h0020, 1'b0, 16'h0040, 16'h0040);
        sb_push("nt1_mis", S_MIS, 16'h0001);
        sb_push("nt1_cpc", S_CPC, 16'h0021);
        settle();
        tick();
        idle_upd();
        sb_push("nt1_ppc", S_PC2, 16'h0040);
        settle();
        tick();
        drive_upd(1'b0, 16'h0020, 1'b0, 16'h0040, 16'h0040);
        sb_push("rdw_ppc", S_PC2, 16'h0040);
        sb_push("nt2_mis", S_MIS, 16'h0001);
        settle();
        tick();
        idle_upd();
        sb_push("nt2_ppc",    S_PC2, 16'h0021);
        sb_push("nt2_tk",     S_TK2, 16'h0000);
        sb_push("nt2_m1_ppc", S_PC1, 16'h0040);
        sb_push("nt2_nb",  S_NB,  16'h0006);
        sb_push("nt2_nbm", S_NBM, 16'h0003);
        settle();

        // Aliasing eviction
        tick();
        pc = 16'h0120;
        drive_upd(1'b0, 16'h0120, 1'b1, 16'h0200, 16'h0121);
        sb_push("alias_m1_miss", S_PC1, 16'h0121);
        sb_push("alias_m2_miss", S_PC2, 16'h0121);
        sb_push("alias_mis", S_MIS, 16'h0001);
        sb_push("alias_cpc", S_CPC, 16'h0200);
        settle();
        tick();
        idle_upd();
        pc = 16'h0020;
        sb_push("evicted_m1", S_PC1, 16'h0021);
        sb_push("evicted_m2", S_PC2, 16'h0021);
        settle();
        pc = 16'h0120;
        sb_push("alias_m0_ppc", S_PC0, 16'h0121);
        sb_push("alias_m1_ppc", S_PC1, 16'h0200);
        sb_push("alias_m2_ppc", S_PC2, 16'h0200);
        sb_push("alias_nb",  S_NB,  16'h0007);
        sb_push("alias_nbm", S_NBM, 16'h0004);
        settle();

        // Jump at the top of the address space; wrap of pc+1
        tick();
        pc = 16'hFFFF;
        drive_upd(1'b1, 16'hFFFF, 1'b0, 16'h0005, 16'h0000);
        sb_push("jmp_mis", S_MIS, 16'h0001);
        sb_push("jmp_cpc", S_CPC, 16'h0005);
        sb_push("wrap_m0_pre", S_PC0, 16'h0000);
        settle();
        tick();
        idle_upd();
        sb_push("wrap_m0_ppc", S_PC0, 16'h0000);
        sb_push("wrap_m0_tk",  S_TK0, 16'h0000);
        sb_push("jmp_m1_ppc",  S_PC1, 16'h0005);
        sb_push("jmp_m2_ppc",  S_PC2, 16'h0005);
        settle();
        tick();
        drive_upd(1'b0, 16'hFFFF, 1'b0, 16'h0005, 16'h0005);
        sb_push("nt_wrap_cpc", S_CPC, 16'h0000);
        sb_push("nt_wrap_mis", S_MIS, 16'h0001);
        settle();
        tick();
        idle_upd();
        sb_push("jmp_ctr_max", S_PC2, 16'h0005);
        sb_push("jmp_nb",  S_NB,  16'h0009);
        sb_push("jmp_nbm", S_NBM, 16'h0006);
        settle();

        // stat_clear wins over a simultaneous mispredict; table still trains
        tick();
        stat_clear = 1'b1;
        pc = 16'h0030;
        drive_upd(1'b0, 16'h0030, 1'b1, 16'h0077, 16'h0031);
        sb_push("clr_mis", S_MIS, 16'h0001);
        sb_push("clr_cpc", S_CPC, 16'h0077);
        settle();
        tick();
        stat_clear = 1'b0;
        idle_upd();
        sb_push("clr_nb",  S_NB,  16'h0000);
        sb_push("clr_nbm", S_NBM, 16'h0000);
        sb_push("clr_m1_ppc", S_PC1, 16'h0077);
        sb_push("clr_m2_ppc", S_PC2, 16'h0077);
        settle();
        tick();
        drive_upd(1'b0, 16'h0030, 1'b1, 16'h0077, 16'h0077);
        sb_push("post_clr_mis", S_MIS, 16'h0000);
        settle();
        tick();
        idle_upd();
        sb_push("post_clr_nb",  S_NB,  16'h0001);
        sb_push("post_clr_nbm", S_NBM, 16'h0000);
        settle();

        // Reset pulse mid-run discards the pending update and empties the table
        tick();
        drive_upd(1'b0, 16'h0040, 1'b1, 16'h0099, 16'h0041);
        #2;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        idle_upd();
        reset_n = 1'b1;
        pc = 16'h0040;
        sb_push("rst_pending", S_PC1, 16'h0041);
        settle();
        pc = 16'h0030;
        sb_push("rst_m1_0030", S_PC1, 16'h0031);
        sb_push("rst_m2_0030", S_PC2, 16'h0031);
        settle();
        pc = 16'hFFFF;
        sb_push("rst_m1_ffff", S_PC1, 16'h0000);
        settle();
        pc = 16'h0120;
        sb_push("rst_m1_0120", S_PC1, 16'h0121);
        sb_push("rst_nb",  S_NB,  16'h0000);
        sb_push("rst_nbm", S_NBM, 16'h0000);
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
